axil_bram_bridge: RTL



---
 rtl/axil_bram_bridge.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave to single-port BRAM strobe bridge for the control/status register file.
// Optional macro AXIL_BRIDGE_WR_PROTECT_EN: writes at or above WR_ADDR_LIMIT get SLVERR, no strobe.
module axil_bram_bridge #(
   parameter int                    ADDR_WIDTH    = 12,
   parameter int                    RD_LATENCY    = 2,
   parameter logic [ADDR_WIDTH-1:0] WR_ADDR_LIMIT = 12'h800
) (
   input  logic                  user_clk,
   input  logic                  user_rst,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [31:0]           s_axil_wdata,
   input  logic [3:0]            s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [31:0]           s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic                  bram_en_a,
   output logic [3:0]            bram_we_a,
   output logic [ADDR_WIDTH-1:0] bram_addr_a,
   output logic [31:0]           bram_wrdata_a,
   input  logic [31:0]           bram_rddata_a
);

   localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ISSUE, S_WR_RESP, S_RD_ISSUE, S_RD_WAIT, S_RD_RESP, S_GAP
   } state_t;

   state_t                r_state;
   logic                  r_aw_full;
   logic [ADDR_WIDTH-1:0] r_aw_addr;
   logic                  r_w_full;
   logic [31:0]           r_w_data;
   logic [3:0]            r_w_strb;
   logic                  r_ar_full;
   logic [ADDR_WIDTH-1:0] r_ar_addr;
   logic                  r_last_wr;
   logic [CNT_W-1:0]      r_cnt;

   logic w_aw_hs, w_w_hs, w_ar_hs;
   logic w_wr_elig, w_rd_elig, w_grant_wr;
   logic w_aw_full_nxt, w_w_full_nxt, w_ar_full_nxt;
   logic w_wr_prot, w_wr_strobe;

`ifdef AXIL_BRIDGE_WR_PROTECT_EN
   assign w_wr_prot = (r_aw_addr >= WR_ADDR_LIMIT);
`else
   assign w_wr_prot = 1'b0;
`endif

   always_comb begin
      w_aw_hs       = s_axil_awvalid && s_axil_awready;
      w_w_hs        = s_axil_wvalid  && s_axil_wready;
      w_ar_hs       = s_axil_arvalid && s_axil_arready;
      w_wr_elig     = r_aw_full && r_w_full;
      w_rd_elig     = r_ar_full;
      w_grant_wr    = w_wr_elig && (!w_rd_elig || !r_last_wr);
      w_wr_strobe   = (|r_w_strb) && !w_wr_prot;
      w_aw_full_nxt = (r_aw_full && (r_state != S_WR_ISSUE)) || w_aw_hs;
      w_w_full_nxt  = (r_w_full  && (r_state != S_WR_ISSUE)) || w_w_hs;
      w_ar_full_nxt = (r_ar_full && (r_state != S_RD_ISSUE)) || w_ar_hs;
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         r_state        <= S_IDLE;
         r_aw_full      <= 1'b0;
         r_aw_addr      <= '0;
         r_w_full       <= 1'b0;
         r_w_data       <= '0;
         r_w_strb       <= '0;
         r_ar_full      <= 1'b0;
         r_ar_addr      <= '0;
         r_last_wr      <= 1'b0;
         r_cnt          <= '0;
         s_axil_awready <= 1'b0;
         s_axil_wready  <= 1'b0;
         s_axil_arready <= 1'b0;
         s_axil_bresp   <= 2'b00;
         s_axil_bvalid  <= 1'b0;
         s_axil_rdata   <= '0;
         s_axil_rresp   <= 2'b00;
         s_axil_rvalid  <= 1'b0;
         bram_en_a      <= 1'b0;
         bram_we_a      <= 4'h0;
         bram_addr_a    <= '0;
         bram_wrdata_a  <= '0;
      end else begin
         if (w_aw_hs) r_aw_addr <= s_axil_awaddr;
         if (w_w_hs) begin
            r_w_data <= s_axil_wdata;
            r_w_strb <= s_axil_wstrb;
         end
         if (w_ar_hs) r_ar_addr <= s_axil_araddr;
         r_aw_full      <= w_aw_full_nxt;
         r_w_full       <= w_w_full_nxt;
         r_ar_full      <= w_ar_full_nxt;
         s_axil_awready <= !w_aw_full_nxt;
         s_axil_wready  <= !w_w_full_nxt;
         s_axil_arready <= !w_ar_full_nxt;

         case (r_state)
            S_IDLE: begin
               // Only contested grants move the fairness flag.
               if (w_wr_elig && w_rd_elig) r_last_wr <= w_grant_wr;
               if (w_grant_wr) begin
                  r_state       <= S_WR_ISSUE;
                  bram_en_a     <= w_wr_strobe;
                  bram_we_a     <= w_wr_strobe ? 4'hF : 4'h0;
                  bram_addr_a   <= r_aw_addr;
                  bram_wrdata_a <= r_w_data;
               end else if (w_rd_elig) begin
                  r_state     <= S_RD_ISSUE;
                  bram_en_a   <= 1'b1;
                  bram_we_a   <= 4'h0;
                  bram_addr_a <= r_ar_addr;
               end
            end
            S_WR_ISSUE: begin
               bram_en_a     <= 1'b0;
               bram_we_a     <= 4'h0;
               s_axil_bvalid <= 1'b1;
               s_axil_bresp  <= w_wr_prot ? 2'b10 : 2'b00;
               r_state       <= S_WR_RESP;
            end
            S_WR_RESP: begin
               if (s_axil_bready) begin
                  s_axil_bvalid <= 1'b0;
                  r_state       <= S_GAP;
               end
            end
            S_RD_ISSUE: begin
               // Issue cycle already spent one of the RD_LATENCY cycles.
               bram_en_a <= 1'b0;
               r_cnt     <= CNT_W'(RD_LATENCY - 1);
               r_state   <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (r_cnt == '0) begin
                  s_axil_rdata  <= bram_rddata_a;
                  s_axil_rresp  <= 2'b00;
                  s_axil_rvalid <= 1'b1;
                  r_state       <= S_RD_RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_RD_RESP: begin
               if (s_axil_rready) begin
                  s_axil_rvalid <= 1'b0;
                  r_state       <= S_GAP;
               end
            end
            S_GAP:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
